// File: rtl/csr_master_arbiter.sv
// csr_master_arbiter: round-robin two-client CSR bus master with full request/ack/read-data sequencing.
module csr_master_arbiter #(parameter int TIMEOUT_CYCLES = 255) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  client_req,
  input  logic [1:0]  client_read_not_write,
  input  logic [15:0] client0_select,
  input  logic [15:0] client1_select,
  input  logic [15:0] client0_address,
  input  logic [15:0] client1_address,
  input  logic [31:0] client0_wdata,
  input  logic [31:0] client1_wdata,
  output logic [1:0]  client_done,
  output logic        client_err,
  output logic [31:0] client_rdata,
  output logic        csr_request__valid,
  output logic        csr_request__read_not_write,
  output logic [15:0] csr_request__select,
  output logic [15:0] csr_request__address,
  output logic [31:0] csr_request__data,
  input  logic        csr_response__ack,
  input  logic        csr_response__read_data_valid,
  input  logic [31:0] csr_response__read_data
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, DATA = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic grant, last_grant, win, fin_ok, fin_to, timeout;
  assign win = &client_req ? ~last_grant : client_req[1];
  assign fin_ok = state == DATA && (csr_request__read_not_write ? csr_response__read_data_valid : !csr_response__ack);
  assign fin_to = timeout && !fin_ok && !(state == REQ && csr_response__ack);
`ifdef CSR_MASTER_ARBITER_TIMEOUT_EN
  logic [7:0] cnt;
  assign timeout = (state == REQ || state == DATA) && cnt == 8'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else cnt <= (state == IDLE || (state == REQ && csr_response__ack)) ? '0 : cnt + 8'd1;
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      grant <= 1'b0;
      last_grant <= 1'b1;
      client_done <= '0;
      client_err <= 1'b0;
      client_rdata <= '0;
      csr_request__valid <= 1'b0;
      csr_request__read_not_write <= 1'b0;
      csr_request__select <= '0;
      csr_request__address <= '0;
      csr_request__data <= '0;
    end else begin
      client_done <= '0;
      client_err <= 1'b0;
      case (state)
        IDLE: if (|client_req) begin
          state <= REQ;
          grant <= win;
          last_grant <= win;
          csr_request__valid <= 1'b1;
          csr_request__read_not_write <= client_read_not_write[win];
          csr_request__select <= win ? client1_select : client0_select;
          csr_request__address <= win ? client1_address : client0_address;
          csr_request__data <= win ? client1_wdata : client0_wdata;
        end
        REQ: if (csr_response__ack) begin
          csr_request__valid <= 1'b0;
          state <= DATA;
        end
        DONE: state <= IDLE;
        default: ;
      endcase
      if (fin_ok || fin_to) begin
        state <= DONE;
        csr_request__valid <= 1'b0;
        client_done <= {grant, ~grant};
        client_err <= fin_to;
        if (csr_request__read_not_write) client_rdata <= fin_to ? '1 : csr_response__read_data;
      end
    end
endmodule

// File: tb/tb_csr_master_arbiter.sv
// tb_csr_master_arbiter: directed latency/priority checks plus randomized traffic against a transaction model.
module tb_csr_master_arbiter;
`ifdef CSR_MASTER_ARBITER_TIMEOUT_EN
  localparam int TO = 8;
  localparam int TOC = 8;
`else
  localparam int TO = 0;
  localparam int TOC = 255;
`endif
  logic clk = 1'b0, reset_n = 1'b0;
  logic [1:0] req = '0, rnw_v = '0;
  logic [15:0] sel_v [2], addr_v [2];
  logic [31:0] wd_v [2];
  logic [1:0] client_done;
  logic client_err;
  logic [31:0] client_rdata;
  logic csr_request__valid, csr_request__read_not_write;
  logic [15:0] csr_request__select, csr_request__address;
  logic [31:0] csr_request__data;
  logic ack = 1'b0, rdv = 1'b0;
  logic [31:0] rd = '0;
  int checks = 0, errors = 0;
  int fix_delay = 1, fix_hold = 1, fix_gap = 0;
  bit rand_mode = 1'b0;
  logic [31:0] fix_rdata = '0;
  csr_master_arbiter #(.TIMEOUT_CYCLES(TOC)) dut (
    .clk(clk), .reset_n(reset_n), .client_req(req), .client_read_not_write(rnw_v),
    .client0_select(sel_v[0]), .client1_select(sel_v[1]),
    .client0_address(addr_v[0]), .client1_address(addr_v[1]),
    .client0_wdata(wd_v[0]), .client1_wdata(wd_v[1]),
    .client_done(client_done), .client_err(client_err), .client_rdata(client_rdata),
    .csr_request__valid(csr_request__valid), .csr_request__read_not_write(csr_request__read_not_write),
    .csr_request__select(csr_request__select), .csr_request__address(csr_request__address),
    .csr_request__data(csr_request__data), .csr_response__ack(ack),
    .csr_response__read_data_valid(rdv), .csr_response__read_data(rd));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask
  int ph = 0, age = 0;
  bit last = 1'b1, who = 1'b0;
  logic [1:0] e_done = '0;
  logic e_err = 1'b0, e_valid = 1'b0, e_rnw = 1'b0;
  logic [15:0] e_sel = '0, e_addr = '0;
  logic [31:0] e_wd = '0, e_rdata = '0;
  task expire;
    e_valid = 1'b0;
    e_done[who] = 1'b1;
    e_err = 1'b1;
    if (e_rnw) e_rdata = '1;
    ph = 3;
  endtask
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph = 0; age = 0; last = 1'b1; who = 1'b0;
      e_done = '0; e_err = 1'b0; e_valid = 1'b0; e_rnw = 1'b0;
      e_sel = '0; e_addr = '0; e_wd = '0; e_rdata = '0;
    end else begin
      e_done = '0;
      e_err = 1'b0;
      if (ph == 0) begin
        if (req != 2'b00) begin
          who = (req == 2'b11) ? !last : req[1];
          last = who;
          e_rnw = rnw_v[who]; e_sel = sel_v[who]; e_addr = addr_v[who]; e_wd = wd_v[who];
          e_valid = 1'b1; ph = 1; age = 0;
        end
      end else if (ph == 1) begin
        if (ack) begin
          e_valid = 1'b0; ph = 2; age = 0;
        end else begin
          age++;
          if (TO != 0 && age == TO) expire();
        end
      end else if (ph == 2) begin
        if (e_rnw ? rdv : !ack) begin
          e_done[who] = 1'b1;
          if (e_rnw) e_rdata = rd;
          ph = 3;
        end else begin
          age++;
          if (TO != 0 && age == TO) expire();
        end
      end else ph = 0;
    end
  end
  always @(negedge clk) begin
    check("done", {30'd0, client_done}, {30'd0, e_done});
    check("err", {31'd0, client_err}, {31'd0, e_err});
    check("rdata", client_rdata, e_rdata);
    check("valid", {31'd0, csr_request__valid}, {31'd0, e_valid});
    check("rnw", {31'd0, csr_request__read_not_write}, {31'd0, e_rnw});
    check("select", {16'd0, csr_request__select}, {16'd0, e_sel});
    check("address", {16'd0, csr_request__address}, {16'd0, e_addr});
    check("wdata", csr_request__data, e_wd);
  end
  initial begin
    int st, cnt, g;
    st = 0; cnt = 0; g = 0;
    forever begin
      @(posedge clk); #1;
      if (!reset_n || client_done != 2'b00) begin
        st = 0; ack = 1'b0; rdv = 1'b0;
      end else begin
        if (st == 0 && csr_request__valid) begin
`ifdef CSR_MASTER_ARBITER_TIMEOUT_EN
          cnt = rand_mode ? ($urandom_range(0, 15) == 0 ? 1000 : int'($urandom_range(0, 3))) : fix_delay;
`else
          cnt = rand_mode ? int'($urandom_range(0, 3)) : fix_delay;
`endif
          st = 1;
        end
        if (st == 1) begin
          if (!csr_request__valid) st = 0;
          else if (cnt == 0) begin
            ack = 1'b1;
            cnt = rand_mode ? int'($urandom_range(1, 5)) : fix_hold;
            st = 2;
          end else cnt--;
        end else if (st == 2) begin
          cnt--;
          if (cnt == 0) begin
            ack = 1'b0;
            g = rand_mode ? int'($urandom_range(0, 3)) : fix_gap;
            st = csr_request__read_not_write ? 3 : 0;
          end
        end
        if (st == 3) begin
          if (g == 0) begin
            rdv = 1'b1; rd = rand_mode ? $urandom : fix_rdata; st = 4;
          end else g--;
        end else if (st == 4) begin
          rdv = 1'b0; st = 0;
        end
      end
    end
  end
  task automatic run_one(input int c, input logic rw, input logic [15:0] s, input logic [15:0] a,
                         input logic [31:0] w, input int exp_lat, input logic exp_v2);
    int n;
    logic v2;
    v2 = 1'b0;
    @(posedge clk); #1;
    rnw_v[c] = rw; sel_v[c] = s; addr_v[c] = a; wd_v[c] = w; req[c] = 1'b1;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check("bus_valid", {31'd0, csr_request__valid}, 32'd1);
        check("bus_select", {16'd0, csr_request__select}, {16'd0, s});
        check("bus_address", {16'd0, csr_request__address}, {16'd0, a});
        check("bus_data", csr_request__data, w);
      end
      if (n == 2) v2 = csr_request__valid;
      if (client_done[c]) break;
    end
    check("latency", n, exp_lat);
    check("valid_cycle2", {31'd0, v2}, {31'd0, exp_v2});
    @(posedge clk); #1;
    req[c] = 1'b0;
  endtask
  initial begin
    int got, w [4];
    logic [1:0] dq;
    for (int c = 0; c < 2; c++) begin sel_v[c] = '0; addr_v[c] = '0; wd_v[c] = '0; end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    fix_delay = 1; fix_hold = 2;
    run_one(0, 1'b0, 16'h0003, 16'h0010, 32'hDEADBEEF, 5, 1'b1);
    check("write_err", {31'd0, client_err}, 32'd0);
    fix_hold = 1; fix_gap = 0; fix_rdata = 32'h12345678;
    run_one(1, 1'b1, 16'h0007, 16'h0004, 32'h0, 4, 1'b1);
    check("read_rdata", client_rdata, 32'h12345678);
    run_one(0, 1'b0, 16'h0001, 16'h0020, 32'hA5A5_0001, 4, 1'b1);
    check("rdata_held", client_rdata, 32'h12345678);
    fix_delay = 0; fix_hold = 6;
    run_one(1, 1'b0, 16'h0002, 16'h0030, 32'h0BAD_F00D, 8, 1'b0);
`ifdef CSR_MASTER_ARBITER_TIMEOUT_EN
    fix_delay = 1000;
    run_one(0, 1'b1, 16'h0099, 16'h0040, 32'h0, 9, 1'b1);
    check("timeout_err", {31'd0, client_err}, 32'd1);
    check("timeout_rdata", client_rdata, 32'hFFFFFFFF);
    fix_delay = 1; fix_hold = 1;
    run_one(1, 1'b0, 16'h0005, 16'h0050, 32'h1111_2222, 4, 1'b1);
`endif
    fix_delay = 6;
    @(posedge clk); #1;
    rnw_v[1] = 1'b0; sel_v[1] = 16'h0008; addr_v[1] = 16'h0060; wd_v[1] = 32'h77; req[1] = 1'b1;
    @(posedge clk); @(posedge clk); #3;
    check("pre_reset_valid", {31'd0, csr_request__valid}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("reset_valid", {31'd0, csr_request__valid}, 32'd0);
    check("reset_done", {30'd0, client_done}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    fix_delay = 1; fix_hold = 1;
    req = 2'b11;
    reset_n = 1'b1;
    got = 0;
    for (int n = 0; n < 200 && got < 4; n++) begin
      @(negedge clk);
      if (client_done != 2'b00) begin w[got] = int'(client_done[1]); got++; end
    end
    check("alt_count", got, 4);
    for (int i = 0; i < 4; i++) check("alt_order", w[i], i % 2);
    @(posedge clk); #1;
    req = 2'b00;
    rand_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      dq = client_done;
      @(posedge clk); #1;
      for (int c = 0; c < 2; c++) begin
        if (dq[c] || !req[c] || $urandom_range(0, 3) == 0) begin
          rnw_v[c] = 1'($urandom); sel_v[c] = 16'($urandom); addr_v[c] = 16'($urandom); wd_v[c] = $urandom;
        end
        if (dq[c] || !req[c]) req[c] = $urandom_range(0, 2) == 0;
      end
    end
    got = 0;
    for (int i = 0; i < 300 && req != 2'b00; i++) begin
      @(negedge clk);
      dq = client_done;
      @(posedge clk); #1;
      for (int c = 0; c < 2; c++) if (dq[c]) req[c] = 1'b0;
      got = i;
    end
    check("drain", {30'd0, req}, 32'd0);
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
